// File: rtl/filter_ctrl_pkg.sv
// rtl/filter_ctrl_pkg.sv - shared types and constants for the filter buffer sequencer
//   Contents: FSM state encoding, words per filter fetch, bytes per stream pass.
package filter_ctrl_pkg;

  localparam int WORDS_PER_F = 4;
  localparam int BYTES_PER_F = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_READY  = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/filter_addr_gen.sv
// rtl/filter_addr_gen.sv - filter memory word address generator for one filter fetch
//   clk, rstN          clock, asynchronous active-low reset
//   clear              synchronous clear of the word counter
//   active             controller is in its load phase
//   baseAddr           word address of filter 0
//   fIdx               index of the filter being fetched
//   memRE              memory read enable, one per word
//   memAddr            baseAddr + WORDS_PER_F*fIdx + word (zero when memRE is low)
//   loadDone           all words issued and the last write strobe is out
module filter_addr_gen
  import filter_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              clear,
  input  logic              active,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [CNT_W-1:0]  fIdx,
  output logic              memRE,
  output logic [ADDR_W-1:0] memAddr,
  output logic              loadDone
);

  localparam int WC_W = $clog2(WORDS_PER_F) + 1;

  logic [WC_W-1:0]   wordCnt;
  logic [ADDR_W-1:0] filterBase;

  // The counter parks at WORDS_PER_F for one extra cycle so the delayed
  // write strobe of the last word lands before the controller moves on.
  assign memRE      = active && (wordCnt < WC_W'(WORDS_PER_F));
  assign loadDone   = active && (wordCnt == WC_W'(WORDS_PER_F));
  assign filterBase = baseAddr + ADDR_W'(fIdx) * ADDR_W'(WORDS_PER_F);
  assign memAddr    = memRE ? (filterBase + ADDR_W'(wordCnt)) : '0;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wordCnt <= '0;
    end else if (clear || !active || loadDone) begin
      wordCnt <= '0;
    end else begin
      wordCnt <= wordCnt + WC_W'(1);
    end
  end

endmodule

// File: rtl/filter_buffer_ctrl.sv
// rtl/filter_buffer_ctrl.sv - layer-2 filter byte buffer sequencer (load 4 words, replay 16 bytes per pass)
//   clk, rstN                      clock, asynchronous active-low reset
//   start, abort                   run request (IDLE only), synchronous abort to IDLE
//   baseAddr, numFilters, reuseCount  run parameters, latched at start
//   peReq                          PE ready for one pass (READY only)
//   memRE, memAddr                 filter memory read port
//   WEFilter, REFilter, rstFilter  buffer write, read/shift and shift-clear strobes
//   filterReady, byteValid         filter loaded / byte on buffer output
//   passDone, allDone, busy        pass end pulse, run end pulse, not-idle flag
module filter_buffer_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [CNT_W-1:0]  numFilters,
  input  logic [CNT_W-1:0]  reuseCount,
  input  logic              peReq,
  output logic              memRE,
  output logic [ADDR_W-1:0] memAddr,
  output logic              WEFilter,
  output logic              REFilter,
  output logic              rstFilter,
  output logic              filterReady,
  output logic              byteValid,
  output logic              passDone,
  output logic              allDone,
  output logic              busy
);

  // STREAM runs BYTES_PER_F read cycles, one cycle for the delayed last
  // byteValid, and one cycle carrying passDone.
  localparam int BC_W        = $clog2(BYTES_PER_F + 2);
  localparam int STREAM_LAST = BYTES_PER_F + 1;

  state_t            state, stateNext;
  logic [CNT_W-1:0]  fCnt, pCnt, fNext, pNext;
  logic [CNT_W-1:0]  numLat, reuseLat;
  logic [ADDR_W-1:0] baseLat;
  logic [BC_W-1:0]   byteCnt;
  logic              loadDone;
  logic              streamEnd;

  filter_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk      (clk),
    .rstN     (rstN),
    .clear    (abort),
    .active   (state == S_LOAD),
    .baseAddr (baseLat),
    .fIdx     (fCnt),
    .memRE    (memRE),
    .memAddr  (memAddr),
    .loadDone (loadDone)
  );

  assign fNext     = fCnt + CNT_W'(1);
  assign pNext     = pCnt + CNT_W'(1);
  assign streamEnd = (state == S_STREAM) && (byteCnt == BC_W'(STREAM_LAST));

  always_comb begin
    stateNext   = state;
    REFilter    = 1'b0;
    rstFilter   = 1'b0;
    filterReady = 1'b0;
    passDone    = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) stateNext = (numFilters == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        if (loadDone) stateNext = S_READY;
      end
      S_READY: begin
        filterReady = 1'b1;
        if (peReq) stateNext = S_STREAM;
      end
      S_STREAM: begin
        REFilter  = (byteCnt < BC_W'(BYTES_PER_F));
        rstFilter = (byteCnt == '0);
        if (streamEnd) begin
          passDone = !abort;
          if (pNext < reuseLat)     stateNext = S_READY;
          else if (fNext < numLat)  stateNext = S_LOAD;
          else                      stateNext = S_DONE;
        end
      end
      S_DONE: begin
        stateNext = S_IDLE;
      end
      default: stateNext = S_IDLE;
    endcase
    if (abort) stateNext = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= S_IDLE;
      fCnt      <= '0;
      pCnt      <= '0;
      byteCnt   <= '0;
      numLat    <= '0;
      reuseLat  <= '0;
      baseLat   <= '0;
      WEFilter  <= 1'b0;
      byteValid <= 1'b0;
      allDone   <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      fCnt      <= '0;
      pCnt      <= '0;
      byteCnt   <= '0;
      WEFilter  <= 1'b0;
      byteValid <= 1'b0;
      allDone   <= 1'b0;
    end else begin
      state     <= stateNext;
      WEFilter  <= memRE;
      byteValid <= REFilter;
      allDone   <= (state == S_DONE);
      byteCnt   <= ((state == S_STREAM) && !streamEnd) ? byteCnt + BC_W'(1) : '0;
      if ((state == S_IDLE) && start) begin
        numLat   <= numFilters;
        reuseLat <= (reuseCount == '0) ? CNT_W'(1) : reuseCount;
        baseLat  <= baseAddr;
        fCnt     <= '0;
        pCnt     <= '0;
      end
      if (streamEnd) begin
        if (pNext < reuseLat) begin
          pCnt <= pNext;
        end else begin
          pCnt <= '0;
          fCnt <= fNext;
        end
      end
    end
  end

endmodule

// File: tb/tb_filter_buffer_ctrl.sv
// tb/tb_filter_buffer_ctrl.sv - directed self-checking bench for filter_buffer_ctrl
module tb_filter_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       peReq = 1'b0;
  logic [7:0] baseAddr = 8'h00;
  logic [7:0] numFilters = 8'h00;
  logic [7:0] reuseCount = 8'h00;
  logic       memRE, WEFilter, REFilter, rstFilter, filterReady;
  logic       byteValid, passDone, allDone, busy;
  logic [7:0] memAddr;
  logic [16:0] outVec;

  filter_buffer_ctrl #(.ADDR_W(8), .CNT_W(8)) dut (
    .clk         (clk),
    .rstN        (rstN),
    .start       (start),
    .abort       (abort),
    .baseAddr    (baseAddr),
    .numFilters  (numFilters),
    .reuseCount  (reuseCount),
    .peReq       (peReq),
    .memRE       (memRE),
    .memAddr     (memAddr),
    .WEFilter    (WEFilter),
    .REFilter    (REFilter),
    .rstFilter   (rstFilter),
    .filterReady (filterReady),
    .byteValid   (byteValid),
    .passDone    (passDone),
    .allDone     (allDone),
    .busy        (busy)
  );

  assign outVec = {memRE, memAddr, WEFilter, REFilter, rstFilter, filterReady,
                   byteValid, passDone, allDone, busy};

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-run monitor; k is the cycle index with k=1 the first cycle after start is sampled.
  int runId = 0, seenRun = 0, k = 0;
  int nMemRE, nWE, nRE, nRst, nBV, nPass, nAll, nReady, nOverlap;
  int firstWE, firstReady, firstRE, firstRst, firstBV, lastBV, firstPass, firstAll;
  logic [7:0] addrLog[$];

  always @(negedge clk) begin
    if (runId != seenRun) begin
      seenRun = runId;
      k = 0;
      nMemRE = 0; nWE = 0; nRE = 0; nRst = 0; nBV = 0; nPass = 0; nAll = 0;
      nReady = 0; nOverlap = 0;
      firstWE = 0; firstReady = 0; firstRE = 0; firstRst = 0; firstBV = 0;
      lastBV = 0; firstPass = 0; firstAll = 0;
      addrLog.delete();
    end
    k++;
    if (memRE) begin nMemRE++; addrLog.push_back(memAddr); end
    if (WEFilter) begin nWE++; if (firstWE == 0) firstWE = k; end
    if (REFilter) begin nRE++; if (firstRE == 0) firstRE = k; end
    if (rstFilter) begin nRst++; if (firstRst == 0) firstRst = k; end
    if (byteValid) begin nBV++; lastBV = k; if (firstBV == 0) firstBV = k; end
    if (passDone) begin nPass++; if (firstPass == 0) firstPass = k; end
    if (allDone) begin nAll++; if (firstAll == 0) firstAll = k; end
    if (filterReady) begin nReady++; if (firstReady == 0) firstReady = k; end
    if (WEFilter && REFilter) nOverlap++;
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic startRun(input logic [7:0] b, input logic [7:0] n, input logic [7:0] r);
    step;
    baseAddr   = b;
    numFilters = n;
    reuseCount = r;
    runId++;
    start = 1'b1;
    step;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int maxc);
    int c = 0;
    while (nAll == 0 && c < maxc) begin
      step;
      c++;
    end
    checkVal(tag, nAll, 1);
    repeat (3) step;
  endtask

  initial begin
    // reset state
    repeat (2) step;
    checkVal("rst_outputs", outVec, 0);
    rstN = 1'b1;
    step;
    checkVal("idle_busy", busy, 0);

    // single filter, single pass
    peReq = 1'b1;
    startRun(8'h10, 8'd1, 8'd1);
    waitDone("t1_done", 200);
    checkVal("t1_memre_cnt", nMemRE, 4);
    checkVal("t1_addrs", {addrLog[0], addrLog[1], addrLog[2], addrLog[3]}, 32'h10111213);
    checkVal("t1_we_cnt", nWE, 4);
    checkVal("t1_we_first", firstWE, 2);
    checkVal("t1_ready_first", firstReady, 6);
    checkVal("t1_re_cnt", nRE, 16);
    checkVal("t1_re_first", firstRE, 7);
    checkVal("t1_rst_cnt", nRst, 1);
    checkVal("t1_rst_first", firstRst, 7);
    checkVal("t1_bv_cnt", nBV, 16);
    checkVal("t1_bv_first", firstBV, 8);
    checkVal("t1_bv_last", lastBV, 23);
    checkVal("t1_pass_cnt", nPass, 1);
    checkVal("t1_pass_first", firstPass, 24);
    checkVal("t1_all_first", firstAll, 26);
    checkVal("t1_overlap", nOverlap, 0);

    // two filters, three passes each
    startRun(8'h20, 8'd2, 8'd3);
    waitDone("t2_done", 1000);
    checkVal("t2_pass_cnt", nPass, 6);
    checkVal("t2_memre_cnt", nMemRE, 8);
    checkVal("t2_addrs2", {addrLog[4], addrLog[5], addrLog[6], addrLog[7]}, 32'h24252627);
    checkVal("t2_we_cnt", nWE, 8);
    checkVal("t2_re_cnt", nRE, 96);
    checkVal("t2_rst_cnt", nRst, 6);
    checkVal("t2_overlap", nOverlap, 0);

    // PE not ready: hold in READY
    peReq = 1'b0;
    startRun(8'h30, 8'd1, 8'd1);
    while (k < 56) step;
    checkVal("t3_ready_cnt", nReady, 51);
    checkVal("t3_re_idle", nRE, 0);
    checkVal("t3_ready_now", filterReady, 1);
    peReq = 1'b1;
    step;
    peReq = 1'b0;
    waitDone("t3_done", 200);
    checkVal("t3_re_first", firstRE, 57);
    checkVal("t3_pass_cnt", nPass, 1);

    // zero filters
    peReq = 1'b1;
    startRun(8'h00, 8'd0, 8'd1);
    waitDone("t4_done", 20);
    checkVal("t4_all_first", firstAll, 2);
    checkVal("t4_memre_cnt", nMemRE, 0);

    // zero reuse behaves as one pass
    startRun(8'h50, 8'd1, 8'd0);
    waitDone("t5_done", 200);
    checkVal("t5_pass_cnt", nPass, 1);
    checkVal("t5_re_cnt", nRE, 16);

    // abort during third read, then restart
    startRun(8'h40, 8'd1, 8'd1);
    step;
    step;
    abort = 1'b1;
    step;
    abort = 1'b0;
    repeat (5) step;
    checkVal("t6_memre_cnt", nMemRE, 3);
    checkVal("t6_we_cnt", nWE, 2);
    checkVal("t6_busy", busy, 0);
    checkVal("t6_pass_cnt", nPass, 0);
    checkVal("t6_all_cnt", nAll, 0);
    startRun(8'h40, 8'd1, 8'd1);
    waitDone("t6_redo_done", 200);
    checkVal("t6_redo_addr0", addrLog[0], 8'h40);
    checkVal("t6_redo_memre", nMemRE, 4);
    checkVal("t6_redo_we", nWE, 4);

    // asynchronous reset in the middle of a stream
    startRun(8'h60, 8'd1, 8'd1);
    while (k < 10) step;
    checkVal("t7_streaming", REFilter, 1);
    rstN = 1'b0;
    #1;
    checkVal("t7_rst_outputs", outVec, 0);
    step;
    rstN = 1'b1;
    step;
    checkVal("t7_busy_after", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
